axis_dac_sequencer: RTL and testbench
=====================================

AXIS_DAC_SEQUENCER -- requirements
Module: axis_dac_sequencer

Interface
REQ-001 The block SHALL have parameter AXIS_TDATA_WIDTH, default 32, the output stream width: two 16-bit lanes, lane A in [15:0] and lane B in [31:16].
REQ-002 The block SHALL have parameter BRAM_ADDR_WIDTH, default 14, the sample-memory address width.
REQ-003 The block SHALL have parameter REPEAT_WIDTH, default 16, the pass-counter width.
REQ-004 Port aclk: input, 1 bit; the single clock for all logic.
REQ-005 Port aresetn: input, 1 bit; synchronous, active-low reset.
REQ-006 Port cfg_start: input, 1 bit; single-cycle start request.
REQ-007 Port cfg_stop: input, 1 bit; single-cycle abort request.
REQ-008 Port cfg_length: input, BRAM_ADDR_WIDTH bits; index of the last sample, so each pass plays cfg_length+1 samples.
REQ-009 Port cfg_repeat: input, REPEAT_WIDTH bits; pass count minus 1.
REQ-010 Port cfg_gain: input, 16 bits; signed Q1.15 gain.
REQ-011 Port bram_porta_addr: output, BRAM_ADDR_WIDTH bits; sample-memory read address.
REQ-012 Port bram_porta_en: output, 1 bit; read enable.
REQ-013 Port bram_porta_rddata: input, AXIS_TDATA_WIDTH bits; read data, valid exactly 1 cycle after the enabled address.
REQ-014 Port m_axis_tdata: output, AXIS_TDATA_WIDTH bits; sample pair sent to the DAC core.
REQ-015 Port m_axis_tvalid: output, 1 bit; output-stream valid.
REQ-016 Port m_axis_tready: input, 1 bit; output-stream ready.
REQ-017 Port sts_busy: output, 1 bit; high whenever the FSM state is not IDLE.
REQ-018 Port sts_done: output, 1 bit; one-cycle pulse on normal completion.
REQ-019 Port sts_addr: output, BRAM_ADDR_WIDTH bits; address of the most recently accepted sample.

Function
REQ-020 The FSM SHALL have states IDLE, PRIME and RUN.
- IDLE -> PRIME on cfg_start with cfg_stop low.
- PRIME -> RUN after one cycle.
- RUN -> IDLE on completion or on cfg_stop.
REQ-021 On leaving IDLE, the block SHALL latch cfg_length and cfg_repeat; later changes to either SHALL NOT affect the run in progress.
REQ-022 Read addresses SHALL run 0..cfg_length, then wrap to 0 while passes remain; the pass counter SHALL decrement at each wrap.
REQ-023 Reads SHALL be issued only when buffer space is guaranteed; a 2-entry skid buffer SHALL absorb the 1-cycle read latency, so that no sample is dropped or duplicated under any m_axis_tready pattern.
REQ-024 Latency, with the gain feature disabled: cfg_start sampled at cycle N -> bram_porta_en high at N+1 -> first m_axis_tvalid at N+3.
REQ-025 While m_axis_tvalid is high and m_axis_tready is low, m_axis_tdata SHALL be held stable.
REQ-026 Completion is the last sample of the last pass being accepted (tvalid & tready) in cycle M. Then:
- sts_done SHALL be high in cycle M+1.
- m_axis_tvalid SHALL be low from M+1.
- The FSM SHALL be in IDLE at M+1.
REQ-027 cfg_stop in PRIME or RUN, sampled at cycle S:
- m_axis_tvalid SHALL be low from S+1.
- Buffered data SHALL be discarded.
- The FSM SHALL return to IDLE.
- sts_done SHALL NOT pulse.
REQ-028 cfg_start SHALL be ignored while sts_busy is high; cfg_start together with cfg_stop in IDLE SHALL be ignored.
REQ-029 Whenever m_axis_tvalid is low, m_axis_tdata SHALL be 0, so that the DAC core outputs midscale/reset.
REQ-030 Edge cases:
- cfg_length = 0 SHALL play one sample per pass.
- cfg_repeat = all-ones SHALL play 2^REPEAT_WIDTH passes without counter overflow.

Reset
REQ-031 While aresetn is low at a clock edge, the following SHALL apply on the next cycle:
- FSM = IDLE.
- m_axis_tvalid = 0, m_axis_tdata = 0.
- bram_porta_en = 0, bram_porta_addr = 0.
- sts_busy = 0, sts_done = 0, sts_addr = 0.
- Skid buffer empty.
REQ-032 Reset asserted mid-run SHALL abort the run exactly like REQ-027, with no sts_done pulse.

Configuration
REQ-033 With macro AXIS_DAC_SEQ_GAIN_EN defined:
- Each 16-bit lane SHALL be multiplied by cfg_gain and shifted arithmetically right by 15.
- The result SHALL saturate to [-32768, 32767].
- One pipeline register SHALL be added, so first tvalid is at N+4.
- cfg_gain SHALL be latched with the other configuration in REQ-021.
REQ-034 Without the macro, cfg_gain SHALL be ignored, samples SHALL pass through unmodified, and REQ-024 latency SHALL apply.

Structure
REQ-035 The FSM state enum, lane width (16) and the Q1.15 saturation limits SHALL be placed in shared package axis_dac_seq_pkg.
REQ-036 The skid buffer SHALL be sub-module axis_dac_seq_skid, a 2-entry valid/ready buffer with a synchronous flush input.

Verification
REQ-037 The bench SHALL cover the following directed scenarios:
- Normal run: cfg_length=3, cfg_repeat=1, tready=1, BRAM[i]=i -> tdata sequence 0,1,2,3,0,1,2,3; sts_done at M+1; first tvalid at N+3.
- Random tready (50%), cfg_length=7, cfg_repeat=2 -> exactly 24 accepted beats in address order, tdata stable while stalled.
- cfg_stop on 5th accepted beat -> tvalid low next cycle, no sts_done, sts_busy low, new start then plays from address 0.
- cfg_start while busy and aresetn low mid-run -> start ignored; after reset all outputs 0 and no sts_done.
- GAIN_EN: cfg_gain=0x4000 with lanes 0x7FFE/0x8000 -> 0x3FFF/0xC000; cfg_gain=0x8000 with lane 0x8000 -> 0x7FFF (saturated); first tvalid at N+4.

Source files
------------

// File: rtl/axis_dac_seq_pkg.sv
// Shared types and constants for the AXI-Stream DAC sequencer.
// Holds the FSM encoding, lane width and Q1.15 gain helper.
package axis_dac_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } seq_state_e;

    localparam int LANE_W  = 16;
    localparam int Q15_MAX = 32767;
    localparam int Q15_MIN = -32768;

    // Signed Q1.15 multiply, arithmetic shift by 15, saturate to 16 bits.
    function automatic logic [LANE_W-1:0] q15_gain(
        input logic [LANE_W-1:0] s,
        input logic [LANE_W-1:0] g
    );
        logic signed [2*LANE_W-1:0] w_prod;
        logic signed [2*LANE_W-1:0] w_shift;
        w_prod  = $signed(s) * $signed(g);
        w_shift = w_prod >>> 15;
        if (w_shift > Q15_MAX)
            return LANE_W'(Q15_MAX);
        if (w_shift < Q15_MIN)
            return LANE_W'(Q15_MIN);
        return w_shift[LANE_W-1:0];
    endfunction

endpackage

// File: rtl/axis_dac_seq_skid.sv
// Two-entry valid/ready buffer with synchronous flush.
// Output data reads as zero whenever the buffer is empty.
module axis_dac_seq_skid #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_cnt;
    logic         w_push;
    logic         w_pop;

    assign o_ready = (r_cnt != 2'd2);
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = o_valid ? r_mem[r_rptr] : '0;
    assign o_count = r_cnt;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop)
                r_rptr <= ~r_rptr;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/axis_dac_sequencer.sv
// Plays BRAM samples out over AXI-Stream for a number of passes.
// Define AXIS_DAC_SEQ_GAIN_EN for per-lane Q1.15 gain (+1 cycle).
module axis_dac_sequencer
    import axis_dac_seq_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH  = 14,
    parameter int REPEAT_WIDTH     = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cfg_start,
    input  logic                        cfg_stop,
    input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_length,
    input  logic [REPEAT_WIDTH-1:0]     cfg_repeat,
    input  logic [15:0]                 cfg_gain,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
    output logic                        bram_porta_en,
    input  logic [AXIS_TDATA_WIDTH-1:0] bram_porta_rddata,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        sts_busy,
    output logic                        sts_done,
    output logic [BRAM_ADDR_WIDTH-1:0]  sts_addr
);

    localparam int DW = AXIS_TDATA_WIDTH;
    localparam int AW = BRAM_ADDR_WIDTH;
    localparam int PW = 1 + AW + DW;

    seq_state_e          r_state;
    seq_state_e          w_state_nxt;
    logic [AW-1:0]       r_addr;
    logic [AW-1:0]       r_len;
    logic [AW-1:0]       r_pend_addr;
    logic [AW-1:0]       r_sts_addr;
    logic [REPEAT_WIDTH-1:0] r_pass;
    logic                r_rd_done;
    logic                r_pend;
    logic                r_pend_last;
    logic                r_done;
    logic                w_busy;
    logic                w_en;
    logic                w_start;
    logic                w_stop;
    logic                w_last_rd;
    logic                w_pop;
    logic                w_finish;
    logic                w_wr;
    logic [PW-1:0]       w_wr_data;
    logic [PW-1:0]       w_head;
    logic                w_head_valid;
    logic                w_unused_rdy;
    logic [1:0]          w_cnt;
    logic [2:0]          w_occ;

    assign w_start   = (r_state == ST_IDLE) && cfg_start && !cfg_stop;
    assign w_stop    = w_busy && cfg_stop;
    assign w_pop     = w_head_valid && m_axis_tready;
    assign w_finish  = w_pop && w_head[PW-1] && (r_state == ST_RUN) && !cfg_stop;
    assign w_last_rd = (r_addr == r_len) && (r_pass == '0);

    always_ff @(posedge aclk) begin
        if (!aresetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_start) w_state_nxt = ST_PRIME;
            ST_PRIME: w_state_nxt = cfg_stop ? ST_IDLE : ST_RUN;
            ST_RUN:   if (cfg_stop || w_finish) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Issue a read only if every sample already owed still fits in the skid.
    always_comb begin
        w_busy = (r_state != ST_IDLE);
        w_en   = w_busy && !r_rd_done && (w_occ < 3'd2 + {2'b0, w_pop});
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_addr      <= '0;
            r_len       <= '0;
            r_pass      <= '0;
            r_rd_done   <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_pend_addr <= '0;
            r_sts_addr  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done      <= w_finish;
            r_pend      <= w_en && !w_stop;
            r_pend_last <= w_last_rd;
            r_pend_addr <= r_addr;
            if (w_pop)
                r_sts_addr <= w_head[DW +: AW];
            if (w_start) begin
                r_len     <= cfg_length;
                r_pass    <= cfg_repeat;
                r_addr    <= '0;
                r_rd_done <= 1'b0;
            end else if (w_en) begin
                if (r_addr != r_len) begin
                    r_addr <= r_addr + 1'b1;
                end else if (r_pass == '0) begin
                    r_rd_done <= 1'b1;
                end else begin
                    r_pass <= r_pass - 1'b1;
                    r_addr <= '0;
                end
            end
        end
    end

`ifdef AXIS_DAC_SEQ_GAIN_EN
    logic [15:0]   r_gain;
    logic          r_g_vld;
    logic          r_g_last;
    logic [AW-1:0] r_g_addr;
    logic [DW-1:0] r_g_data;
    logic [DW-1:0] w_gained;

    always_comb begin
        w_gained = '0;
        for (int i = 0; i < DW / LANE_W; i++)
            w_gained[i*LANE_W +: LANE_W] =
                q15_gain(bram_porta_rddata[i*LANE_W +: LANE_W], r_gain);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_gain   <= '0;
            r_g_vld  <= 1'b0;
            r_g_last <= 1'b0;
            r_g_addr <= '0;
            r_g_data <= '0;
        end else begin
            if (w_start)
                r_gain <= cfg_gain;
            r_g_vld  <= r_pend && !w_stop;
            r_g_last <= r_pend_last;
            r_g_addr <= r_pend_addr;
            r_g_data <= w_gained;
        end
    end

    assign w_wr      = r_g_vld;
    assign w_wr_data = {r_g_last, r_g_addr, r_g_data};
    assign w_occ     = {1'b0, w_cnt} + {2'b0, r_pend} + {2'b0, r_g_vld};
`else
    logic w_unused_gain;

    assign w_unused_gain = ^cfg_gain;
    assign w_wr          = r_pend;
    assign w_wr_data     = {r_pend_last, r_pend_addr, bram_porta_rddata};
    assign w_occ         = {1'b0, w_cnt} + {2'b0, r_pend};
`endif

    axis_dac_seq_skid #(
        .W (PW)
    ) u_skid (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .i_flush (w_stop),
        .i_valid (w_wr),
        .i_data  (w_wr_data),
        .o_ready (w_unused_rdy),
        .o_valid (w_head_valid),
        .o_data  (w_head),
        .i_ready (m_axis_tready),
        .o_count (w_cnt)
    );

    assign bram_porta_addr = r_addr;
    assign bram_porta_en   = w_en;
    assign m_axis_tdata    = w_head[DW-1:0];
    assign m_axis_tvalid   = w_head_valid;
    assign sts_busy        = w_busy;
    assign sts_done        = r_done;
    assign sts_addr        = r_sts_addr;

endmodule

// File: tb/tb_axis_dac_sequencer.sv
// Self-checking bench for axis_dac_sequencer.
// Table vectors, randomized runs and directed corner sequences.
module tb_axis_dac_sequencer;

    localparam int DW = 32;
    localparam int AW = 14;
    localparam int RW = 4;
`ifdef AXIS_DAC_SEQ_GAIN_EN
    localparam bit GAIN_ON = 1'b1;
    localparam int LAT     = 4;
`else
    localparam bit GAIN_ON = 1'b0;
    localparam int LAT     = 3;
`endif

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    typedef struct {
        int len;
        int rep;
        int pct;
        int stop_at;
        int beats;
    } vec_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_stop = 1'b0;
    logic [AW-1:0] cfg_length = '0;
    logic [RW-1:0] cfg_repeat = '0;
    logic [15:0]   cfg_gain = 16'h6000;
    logic [AW-1:0] bram_porta_addr;
    logic          bram_porta_en;
    logic [DW-1:0] bram_porta_rddata = '0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          sts_busy;
    logic          sts_done;
    logic [AW-1:0] sts_addr;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] last_data;
    logic [DW-1:0] mem [1 << AW];

    axis_dac_sequencer #(
        .AXIS_TDATA_WIDTH (DW),
        .BRAM_ADDR_WIDTH  (AW),
        .REPEAT_WIDTH     (RW)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .cfg_start         (cfg_start),
        .cfg_stop          (cfg_stop),
        .cfg_length        (cfg_length),
        .cfg_repeat        (cfg_repeat),
        .cfg_gain          (cfg_gain),
        .bram_porta_addr   (bram_porta_addr),
        .bram_porta_en     (bram_porta_en),
        .bram_porta_rddata (bram_porta_rddata),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .sts_busy          (sts_busy),
        .sts_done          (sts_done),
        .sts_addr          (sts_addr)
    );

    always #5 aclk = ~aclk;

    // One-cycle-latency sample memory.
    always @(posedge aclk)
        if (bram_porta_en)
            bram_porta_rddata <= mem[bram_porta_addr];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    // Expected output word: pass-through, or per-lane Q1.15 gain.
    function automatic logic [DW-1:0] expect_word(input logic [DW-1:0] w,
                                                  input logic [15:0] gain);
        logic [DW-1:0] r;
        int a;
        int g;
        int p;
        if (!GAIN_ON)
            return w;
        r = '0;
        g = int'($signed(gain));
        for (int l = 0; l < DW / 16; l++) begin
            a = int'($signed(w[16*l +: 16]));
            p = (a * g) >>> 15;
            if (p > 32767)  p = 32767;
            if (p < -32768) p = -32768;
            r[16*l +: 16] = p[15:0];
        end
        return r;
    endfunction

    task automatic run_seq(input int len, input int rep, input int pct,
                           input int stop_at, input int exp_beats,
                           input logic [15:0] gain);
        beat_t         q[$];
        beat_t         b;
        logic [DW-1:0] held = '0;
        logic          stalled = 1'b0;
        logic          got = 1'b0;
        logic          stopped = 1'b0;
        logic          fin = 1'b0;
        int            n = 0;
        int            acc = 0;
        int            first = -1;
        for (int p = 0; p <= rep; p++)
            for (int i = 0; i <= len; i++) begin
                b.a = AW'(i);
                b.d = expect_word(mem[i], gain);
                q.push_back(b);
            end
        cfg_length = AW'(len);
        cfg_repeat = RW'(rep);
        cfg_gain   = gain;
        cfg_start  = 1'b1;
        cyc();
        cfg_start  = 1'b0;
        cfg_length = AW'($urandom);
        cfg_repeat = RW'($urandom);
        cfg_gain   = 16'($urandom);
        n = 1;
        chk("en_at_n1", 64'(bram_porta_en), 64'd1);
        chk("busy_at_n1", 64'(sts_busy), 64'd1);
        while (!fin && n < 2000) begin
            m_axis_tready = ($urandom_range(99) < pct);
            if (m_axis_tvalid && first < 0) begin
                first = n;
                chk("first_tvalid", 64'(n), 64'(LAT));
            end
            if (!m_axis_tvalid)
                chk("tdata_idle", 64'(m_axis_tdata), 64'd0);
            if (stalled)
                chk("hold", {31'd0, m_axis_tvalid, m_axis_tdata},
                    {31'd0, 1'b1, held});
            chk("done_quiet", 64'(sts_done), 64'd0);
            stalled = m_axis_tvalid && !m_axis_tready;
            held    = m_axis_tdata;
            got     = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat actual=%0h required=none",
                             m_axis_tdata);
                    fin = 1'b1;
                end else begin
                    b = q.pop_front();
                    chk("data", 64'(m_axis_tdata), 64'(b.d));
                    last_data = m_axis_tdata;
                    acc++;
                    got = 1'b1;
                    if (acc == stop_at) begin
                        cfg_stop = 1'b1;
                        stopped  = 1'b1;
                        fin      = 1'b1;
                    end else if (q.size() == 0) begin
                        fin = 1'b1;
                    end
                end
            end
            cyc();
            cfg_stop = 1'b0;
            n++;
            if (got)
                chk("sts_addr", 64'(sts_addr), 64'(b.a));
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout actual=%0d required=%0d", acc, exp_beats);
        end
        chk("beats", 64'(acc), 64'(exp_beats));
        chk("tvalid_end", 64'(m_axis_tvalid), 64'd0);
        chk("tdata_end", 64'(m_axis_tdata), 64'd0);
        chk("busy_end", 64'(sts_busy), 64'd0);
        chk("done_end", 64'(sts_done), stopped ? 64'd0 : 64'd1);
        m_axis_tready = 1'b0;
        repeat (3) begin
            cyc();
            chk("done_after", 64'(sts_done), 64'd0);
            chk("busy_after", 64'(sts_busy), 64'd0);
        end
    endtask

    vec_t  vecs [7];
    beat_t bq[$];
    beat_t bb;

    initial begin
        vecs[0] = '{len: 3, rep: 1,  pct: 100, stop_at: -1, beats: 8};
        vecs[1] = '{len: 7, rep: 2,  pct: 50,  stop_at: -1, beats: 24};
        vecs[2] = '{len: 6, rep: 1,  pct: 100, stop_at: 5,  beats: 5};
        vecs[3] = '{len: 0, rep: 0,  pct: 100, stop_at: -1, beats: 1};
        vecs[4] = '{len: 0, rep: 15, pct: 100, stop_at: -1, beats: 16};
        vecs[5] = '{len: 2, rep: 3,  pct: 25,  stop_at: -1, beats: 12};
        vecs[6] = '{len: 5, rep: 1,  pct: 60,  stop_at: 3,  beats: 3};

        for (int i = 0; i < (1 << AW); i++)
            mem[i] = DW'(i);

        repeat (3) cyc();
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_en", 64'(bram_porta_en), 64'd0);
        chk("rst_addr", 64'(bram_porta_addr), 64'd0);
        chk("rst_busy", 64'(sts_busy), 64'd0);
        chk("rst_done", 64'(sts_done), 64'd0);
        chk("rst_sts_addr", 64'(sts_addr), 64'd0);
        aresetn = 1'b1;
        cyc();

        for (int v = 0; v < 7; v++)
            run_seq(vecs[v].len, vecs[v].rep, vecs[v].pct,
                    vecs[v].stop_at, vecs[v].beats, 16'h6000);

        // start together with stop in IDLE is ignored
        cfg_start = 1'b1;
        cfg_stop  = 1'b1;
        cyc();
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        chk("startstop_busy", 64'(sts_busy), 64'd0);
        chk("startstop_en", 64'(bram_porta_en), 64'd0);
        cyc();
        chk("startstop_busy2", 64'(sts_busy), 64'd0);

        for (int r = 0; r < 6; r++) begin
            int len;
            int rep;
            for (int i = 0; i < 16; i++)
                mem[i] = $urandom;
            len = int'($urandom_range(15));
            rep = int'($urandom_range(3));
            run_seq(len, rep, int'($urandom_range(100, 20)), -1,
                    (len + 1) * (rep + 1), 16'($urandom));
        end

`ifdef AXIS_DAC_SEQ_GAIN_EN
        mem[0] = {16'h8000, 16'h7FFE};
        run_seq(0, 0, 100, -1, 1, 16'h4000);
        chk("gain_half", 64'(last_data), 64'h0000_0000_C000_3FFF);
        mem[0] = {16'h8000, 16'h8000};
        run_seq(0, 0, 100, -1, 1, 16'h8000);
        chk("gain_sat", 64'(last_data), 64'h0000_0000_7FFF_7FFF);
`endif

        // start while busy is ignored, then reset mid-run
        for (int i = 0; i < 16; i++)
            mem[i] = DW'(i + 100);
        for (int p = 0; p <= 2; p++)
            for (int i = 0; i <= 9; i++) begin
                bb.a = AW'(i);
                bb.d = expect_word(mem[i], 16'h6000);
                bq.push_back(bb);
            end
        cfg_gain      = 16'h6000;
        cfg_length    = AW'(9);
        cfg_repeat    = RW'(2);
        cfg_start     = 1'b1;
        m_axis_tready = 1'b1;
        cyc();
        cfg_start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 4) begin
                cfg_start  = 1'b1;
                cfg_length = AW'(1);
            end else begin
                cfg_start = 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                bb = bq.pop_front();
                chk("busy_start_data", 64'(m_axis_tdata), 64'(bb.d));
            end
            cyc();
        end
        cfg_start = 1'b0;
        chk("busy_still", 64'(sts_busy), 64'd1);
        aresetn = 1'b0;
        cyc();
        chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mid_rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("mid_rst_en", 64'(bram_porta_en), 64'd0);
        chk("mid_rst_addr", 64'(bram_porta_addr), 64'd0);
        chk("mid_rst_busy", 64'(sts_busy), 64'd0);
        chk("mid_rst_done", 64'(sts_done), 64'd0);
        chk("mid_rst_sts_addr", 64'(sts_addr), 64'd0);
        aresetn = 1'b1;
        repeat (4) begin
            cyc();
            chk("post_rst_done", 64'(sts_done), 64'd0);
            chk("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        end

        run_seq(3, 0, 100, -1, 4, 16'h6000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
